bcd_updown_counter: RTL
=======================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable.
REQ-005 The block SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-006 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-007 The block SHALL have port load_val, input, 4*DIGITS bits: load value, digit i in bits [4i+3:4i].
REQ-008 The block SHALL have port q, output, 4*DIGITS bits: registered BCD count, digit 0 least significant.
REQ-009 The block SHALL have port wrap, output, 1 bit: registered, high for exactly one cycle after a wrap-around.
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal count, high when q = all 9s and up=1, or q = all 0s and up=0.

Function
REQ-011 Priority per rising edge SHALL be load > en > hold.
REQ-012 With load=1, q SHALL take load_val on the next edge; wrap SHALL be 0; any loaded digit greater than 9 SHALL be stored as 9.
REQ-013 With load=0 and en=1, q SHALL change by exactly +1 (up=1) or -1 (up=0) in decimal in one cycle, with latency 1 clock.
REQ-014 Up count: a digit at 9 SHALL become 0 and carry into the next digit; a digit below 9 SHALL increment, and higher digits SHALL hold.
REQ-015 Down count: a digit at 0 SHALL become 9 and borrow from the next digit; a digit above 0 SHALL decrement, and higher digits SHALL hold.
REQ-016 Up from all 9s SHALL give all 0s; down from all 0s SHALL give all 9s. In both cases wrap SHALL be 1 on that same edge.
REQ-017 wrap SHALL be 0 on every edge that is not a wrap-around step.
REQ-018 With load=0 and en=0, q SHALL hold and wrap SHALL be 0.
REQ-019 A change of up in the same cycle as en=1 SHALL take effect on that edge, with no pipeline delay.
REQ-020 q SHALL never hold a digit value above 9 after reset, under any input sequence.
REQ-021 tc SHALL depend only on q and up, with no dependence on en or load.

Reset
REQ-022 Asserting reset SHALL immediately force q=0 and wrap=0, independent of clk.
REQ-023 While reset=1, load and en SHALL be ignored.
REQ-024 After reset deasserts, the first active edge SHALL act per REQ-011; a reset asserted mid-count SHALL discard any carry in flight.

Configuration
REQ-025 Macro BCD_CNT_SAT_EN SHALL select saturating mode.
- Defined: up at all 9s SHALL hold at all 9s, and down at all 0s SHALL hold at all 0s; wrap SHALL be tied to 0; load SHALL be unaffected.
- Undefined: wrap-around per REQ-016.

Verification (DIGITS=4 unless noted)
REQ-026 Reset, then en=1, up=1 for 10000 cycles -> q steps 0000..9999 then 0000; wrap high exactly once, on the 9999->0000 edge.
REQ-027 Load 0199, then en=1, up=1 for one cycle -> q=0200; wrap=0.
REQ-028 Load 1000, then en=1, up=0 for two cycles -> q=0999, then q=0998.
REQ-029 Load 0000, then en=1, up=0 -> q=9999 and wrap=1 without the macro; q=0000 and wrap=0 with BCD_CNT_SAT_EN.
REQ-030 load=1 and en=1 in the same cycle with load_val=F3A7 -> q=9397.
REQ-031 Assert reset asynchronously between edges with q=5678 -> q=0000 before the next clk edge; DIGITS=1 run wraps 9->0.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter with synchronous parallel load.
// Each digit is a 4-bit BCD value; digit 0 is the least significant.
//
// Optional build macro:
//   BCD_CNT_SAT_EN  - saturating mode: counting up at all 9s or down at all
//                     0s holds the value instead of wrapping; wrap is tied 0.
//                     Undefined (default): the counter wraps around and pulses
//                     wrap for one cycle.
//
// Parameters:
//   DIGITS    - number of BCD digits, 1..8
//
// Ports:
//   clk       - clock, all state changes on its rising edge
//   reset     - asynchronous active-high reset, clears q and wrap
//   en        - count enable
//   up        - direction, 1 = count up, 0 = count down
//   load      - synchronous load strobe (priority over en)
//   load_val  - load value, digits above 9 are stored as 9
//   q         - registered BCD count
//   wrap      - registered, high for one cycle after a wrap-around step
//   tc        - combinational terminal count (all 9s going up, all 0s down)
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                wrap,
    output logic                tc
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]    count_q;
    logic [W-1:0]    count_d;
    logic [W-1:0]    step_val;
    logic [W-1:0]    load_clamped;
    logic [DIGITS:0] carry;
    logic            wrap_q;
    logic            wrap_d;

    // Ripple carry/borrow chain. carry[i] means digit i must change this step;
    // carry[DIGITS] is set only when every digit sits at its terminal value,
    // which is exactly the terminal-count condition.
    always_comb begin : step_logic
        carry        = '0;
        carry[0]     = 1'b1;
        step_val     = count_q;
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry[i]) begin
                if (up) begin
                    step_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0
                                                                    : count_q[4*i +: 4] + 4'd1;
                end else begin
                    step_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9
                                                                    : count_q[4*i +: 4] - 4'd1;
                end
            end
            carry[i+1] = carry[i] & (up ? (count_q[4*i +: 4] == 4'd9)
                                        : (count_q[4*i +: 4] == 4'd0));
            // Non-BCD load digits are clamped so q never leaves the BCD range.
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    always_comb begin : next_state
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (!carry[DIGITS]) begin
                count_d = step_val;
            end
`else
            count_d = step_val;
            wrap_d  = carry[DIGITS];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;
    assign tc   = carry[DIGITS];

endmodule
